// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    // Top-level sequencing: optional RAM clear sweep, then normal arbitration.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    // Port indices, also the encoding of the round-robin last-grant pointer.
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    // RAM depth for the default address width.
    localparam int DEFAULT_ADDR_SIZE = 8;
    localparam int RAM_DEPTH         = 2 ** DEFAULT_ADDR_SIZE;

    // Depth of a RAM with the given address width.
    function automatic int ram_depth(input int addr_size);
        return 2 ** addr_size;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin arbiter holding the last-grant pointer.
// Latency: combinational grant; pointer updates on the granting edge.
// Backpressure: no grant while en is low; the pointer then holds its value.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    localparam logic PTR_A = 1'(PORT_A);
    localparam logic PTR_B = 1'(PORT_B);

    logic last;

    // Remember which port was granted most recently; idle cycles leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PTR_B;
        end else if (gnt_a) begin
            last <= PTR_A;
        end else if (gnt_b) begin
            last <= PTR_B;
        end
    end

    // A lone request wins outright; on contention the port not served last wins.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                if (last == PTR_B) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates instruction-fetch port A and load/store port B onto one single-port RAM.
// Latency: grant combinational; read data returns one cycle after the read grant.
// Backpressure: requester holds its command until gnt; no grants while busy.
// Optional macro RAM_ARB_CLEAR_EN: zero the whole RAM after reset before serving requests.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int addr_size = 8,
    parameter int data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [addr_size-1:0] a_addr,
    input  logic [data_size-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [data_size-1:0] a_rdata,

    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [addr_size-1:0] b_addr,
    input  logic [data_size-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [data_size-1:0] b_rdata,

    output logic                 ram_write_en,
    output logic [addr_size-1:0] ram_write_adress,
    output logic [data_size-1:0] ram_data_in,
    output logic                 ram_rd_en,
    output logic [addr_size-1:0] ram_rd_adress,
    input  logic [data_size-1:0] ram_data_out,

    output logic                 busy
);

    arb_state_t           state;
    logic                 clr_vld;
    logic [addr_size-1:0] clr_addr;
    logic                 run_en;

`ifdef RAM_ARB_CLEAR_EN
    localparam logic [addr_size-1:0] CLR_LAST = addr_size'(ram_depth(addr_size) - 1);

    arb_state_t state_nxt;

    // State register: every reset restarts the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep address walks the RAM one word per cycle while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Leave CLEAR once the last address has been written this cycle.
    always_comb begin
        state_nxt = state;
        clr_vld   = 1'b0;
        case (state)
            CLEAR: begin
                clr_vld = 1'b1;
                if (clr_addr == CLR_LAST) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end
`else
    // No sweep: arbitration is live as soon as reset falls.
    assign state    = RUN;
    assign clr_vld  = 1'b0;
    assign clr_addr = '0;
`endif

    assign run_en = !rst && (state == RUN);
    assign busy   = !run_en;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (run_en),
        .req_a (a_req),
        .req_b (b_req),
        .gnt_a (a_gnt),
        .gnt_b (b_gnt)
    );

    // Drive exactly one RAM command per cycle: sweep write, or the granted port's op.
    always_comb begin
        ram_write_en     = 1'b0;
        ram_write_adress = '0;
        ram_data_in      = '0;
        ram_rd_en        = 1'b0;
        ram_rd_adress    = '0;
        if (!rst) begin
            if (clr_vld) begin
                ram_write_en     = 1'b1;
                ram_write_adress = clr_addr;
            end else if (a_gnt) begin
                if (a_we) begin
                    ram_write_en     = 1'b1;
                    ram_write_adress = a_addr;
                    ram_data_in      = a_wdata;
                end else begin
                    ram_rd_en     = 1'b1;
                    ram_rd_adress = a_addr;
                end
            end else if (b_gnt) begin
                if (b_we) begin
                    ram_write_en     = 1'b1;
                    ram_write_adress = b_addr;
                    ram_data_in      = b_wdata;
                end else begin
                    ram_rd_en     = 1'b1;
                    ram_rd_adress = b_addr;
                end
            end
        end
    end

    // Owner tag of the read in flight; reset drops any pending return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
        end
    end

    logic [data_size-1:0] a_hold;
    logic [data_size-1:0] b_hold;

    // Capture returned data so each port's rdata holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            if (a_rvalid) begin
                a_hold <= ram_data_out;
            end
            if (b_rvalid) begin
                b_hold <= ram_data_out;
            end
        end
    end

    assign a_rdata = a_rvalid ? ram_data_out : a_hold;
    assign b_rdata = b_rvalid ? ram_data_out : b_hold;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset corner cases, and
// randomized traffic checked against a port-level behavioural model.
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, a_we, a_gnt, a_rvalid;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       b_req, b_we, b_gnt, b_rvalid;
    logic [7:0] b_addr, b_wdata, b_rdata;
    logic       ram_write_en, ram_rd_en, busy;
    logic [7:0] ram_write_adress, ram_data_in, ram_rd_adress, ram_data_out;

    int n_chk  = 0;
    int n_fail = 0;

    ram_arbiter #(.addr_size(8), .data_size(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_write_en(ram_write_en), .ram_write_adress(ram_write_adress),
        .ram_data_in(ram_data_in), .ram_rd_en(ram_rd_en),
        .ram_rd_adress(ram_rd_adress), .ram_data_out(ram_data_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: registered read, plus a backdoor load port for the bench.
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_write_en) mem[ram_write_adress] <= ram_data_in;
        if (ram_rd_en) ram_data_out <= mem[ram_rd_adress];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_agnt"}, 32'(a_gnt), 0);
        chk({tag, "_bgnt"}, 32'(b_gnt), 0);
        chk({tag, "_arv"}, 32'(a_rvalid), 0);
        chk({tag, "_brv"}, 32'(b_rvalid), 0);
        chk({tag, "_ard"}, 32'(a_rdata), 0);
        chk({tag, "_brd"}, 32'(b_rdata), 0);
        chk({tag, "_ram"}, 32'({ram_write_en, ram_rd_en, ram_write_adress,
                                ram_data_in, ram_rd_adress}), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
    endtask

    // Assert reset now, check it, release on a clock-aligned point.
    task automatic do_reset();
`ifdef RAM_ARB_CLEAR_EN
        int k;
`endif
        rst = 1'b1;
        #1 chk_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_hold");
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        k = 0;
        @(negedge clk);
        while (busy && k < 270) begin
            chk("sweep_we", 32'(ram_write_en), 1);
            chk("sweep_addr", 32'(ram_write_adress), 32'(k % 256));
            chk("sweep_data", 32'(ram_data_in), 0);
            chk("sweep_gnt", 32'({a_gnt, b_gnt}), 0);
            k++;
            @(negedge clk);
        end
        chk("sweep_len", 32'(k), 256);
`else
        #1 chk("busy_after_rst", 32'(busy), 0);
`endif
    endtask

    task automatic preload(input logic [7:0] ad, input logic [7:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = ad; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    typedef struct {
        logic       a_req, a_we; logic [7:0] a_addr, a_wd;
        logic       b_req, b_we; logic [7:0] b_addr, b_wd;
        logic       e_ag, e_bg, e_we, e_re; logic [7:0] e_addr, e_wd;
        logic       e_arv, e_brv; logic [7:0] e_ard, e_brd;
    } vec_t;

    function automatic vec_t mk(input logic ar, aw, input logic [7:0] aa, awd,
                                input logic br, bw, input logic [7:0] ba, bwd,
                                input logic ag, bg, we, re, input logic [7:0] ea, ewd,
                                input logic arv, brv, input logic [7:0] ard, brd);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wd = awd;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wd = bwd;
        v.e_ag = ag; v.e_bg = bg; v.e_we = we; v.e_re = re; v.e_addr = ea; v.e_wd = ewd;
        v.e_arv = arv; v.e_brv = brv; v.e_ard = ard; v.e_brd = brd;
        return v;
    endfunction

    vec_t vecs [15];

    // Reference model state for the random phase.
    logic [7:0] ref_mem [256];
    bit         a_p, b_p, last_b, nrv_a, nrv_b, wa, wb, e_we, e_re;
    logic [7:0] nd_a, nd_b, ea_rd, eb_rd;

    initial begin
        rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

`ifdef RAM_ARB_CLEAR_EN
        // A read held through the whole sweep is served in the first RUN cycle.
        a_req = 1; a_we = 0; a_addr = 8'h10;
        do_reset();
        chk("held_req_gnt", 32'({a_gnt, b_gnt}), 32'b10);
        @(posedge clk); #1;
        a_req = 0;
        @(posedge clk); #1;
`endif
        do_reset();
        preload(8'h01, 8'h11);
        preload(8'h02, 8'h22);
        preload(8'h10, 8'h5A);

        //            A: req we addr wd      B: req we addr wd      agnt bgnt we re addr wd    arv brv ard   brd
        vecs[0]  = mk(1, 0, 8'h01, 8'h00,  1, 0, 8'h02, 8'h00,  1, 0, 0, 1, 8'h01, 8'h00,  0, 0, 8'h00, 8'h00);
        vecs[1]  = mk(1, 0, 8'h01, 8'h00,  1, 0, 8'h02, 8'h00,  0, 1, 0, 1, 8'h02, 8'h00,  1, 0, 8'h11, 8'h00);
        vecs[2]  = mk(1, 0, 8'h01, 8'h00,  1, 0, 8'h02, 8'h00,  1, 0, 0, 1, 8'h01, 8'h00,  0, 1, 8'h11, 8'h22);
        vecs[3]  = mk(1, 0, 8'h01, 8'h00,  1, 0, 8'h02, 8'h00,  0, 1, 0, 1, 8'h02, 8'h00,  1, 0, 8'h11, 8'h22);
        vecs[4]  = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00,  0, 1, 8'h11, 8'h22);
        vecs[5]  = mk(1, 0, 8'h10, 8'h00,  0, 0, 8'h00, 8'h00,  1, 0, 0, 1, 8'h10, 8'h00,  0, 0, 8'h11, 8'h22);
        vecs[6]  = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00,  1, 0, 8'h5A, 8'h22);
        vecs[7]  = mk(0, 0, 8'h00, 8'h00,  1, 1, 8'h80, 8'h33,  0, 1, 1, 0, 8'h80, 8'h33,  0, 0, 8'h5A, 8'h22);
        vecs[8]  = mk(1, 0, 8'h80, 8'h00,  0, 0, 8'h00, 8'h00,  1, 0, 0, 1, 8'h80, 8'h00,  0, 0, 8'h5A, 8'h22);
        vecs[9]  = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00,  1, 0, 8'h33, 8'h22);
        vecs[10] = mk(1, 1, 8'h05, 8'h77,  1, 0, 8'h80, 8'h00,  0, 1, 0, 1, 8'h80, 8'h00,  0, 0, 8'h33, 8'h22);
        vecs[11] = mk(1, 1, 8'h05, 8'h77,  0, 0, 8'h00, 8'h00,  1, 0, 1, 0, 8'h05, 8'h77,  0, 1, 8'h33, 8'h33);
        vecs[12] = mk(0, 0, 8'h00, 8'h00,  1, 0, 8'h05, 8'h00,  0, 1, 0, 1, 8'h05, 8'h00,  0, 0, 8'h33, 8'h33);
        vecs[13] = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00,  0, 1, 8'h33, 8'h77);
        vecs[14] = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00,  0, 0, 8'h33, 8'h77);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wd;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wd;
            @(negedge clk);
            chk($sformatf("v%0d_agnt", i), 32'(a_gnt), 32'(vecs[i].e_ag));
            chk($sformatf("v%0d_bgnt", i), 32'(b_gnt), 32'(vecs[i].e_bg));
            chk($sformatf("v%0d_we", i), 32'(ram_write_en), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_re", i), 32'(ram_rd_en), 32'(vecs[i].e_re));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_waddr", i), 32'(ram_write_adress), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d_wdata", i), 32'(ram_data_in), 32'(vecs[i].e_wd));
            end
            if (vecs[i].e_re)
                chk($sformatf("v%0d_raddr", i), 32'(ram_rd_adress), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_arv", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
            chk($sformatf("v%0d_brv", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
            chk($sformatf("v%0d_ard", i), 32'(a_rdata), 32'(vecs[i].e_ard));
            chk($sformatf("v%0d_brd", i), 32'(b_rdata), 32'(vecs[i].e_brd));
        end

        // Reset in the cycle after a read grant: the return must vanish.
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 8'h10; b_req = 0;
        @(negedge clk);
        chk("midrd_gnt", 32'(a_gnt), 1);
        @(posedge clk); #1;
        a_req = 0;
        do_reset();

        // Pointer is back at B, so A wins the first contention.
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 8'h01; b_req = 1; b_we = 0; b_addr = 8'h02;
        @(negedge clk);
        chk("post_rst_contend", 32'({a_gnt, b_gnt}), 32'b10);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        do_reset();

        // Randomized traffic over a small address window to provoke RAW reuse.
        for (int ad = 0; ad < 16; ad++) begin
            ref_mem[ad] = 8'($urandom);
            preload(8'(ad), ref_mem[ad]);
        end
        a_p = 0; b_p = 0; last_b = 1; nrv_a = 0; nrv_b = 0;
        ea_rd = '0; eb_rd = '0; nd_a = '0; nd_b = '0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (!a_p && $urandom_range(0, 9) < 6) begin
                a_p = 1; a_we = 1'($urandom_range(0, 1));
                a_addr = 8'($urandom_range(0, 15)); a_wdata = 8'($urandom);
            end
            if (!b_p && $urandom_range(0, 9) < 6) begin
                b_p = 1; b_we = 1'($urandom_range(0, 1));
                b_addr = 8'($urandom_range(0, 15)); b_wdata = 8'($urandom);
            end
            a_req = a_p; b_req = b_p;
            @(negedge clk);
            wa = a_p && (!b_p || last_b);
            wb = b_p && !wa;
            if (nrv_a) ea_rd = nd_a;
            if (nrv_b) eb_rd = nd_b;
            e_we = (wa && a_we) || (wb && b_we);
            e_re = (wa && !a_we) || (wb && !b_we);
            chk("rnd_agnt", 32'(a_gnt), 32'(wa));
            chk("rnd_bgnt", 32'(b_gnt), 32'(wb));
            chk("rnd_we", 32'(ram_write_en), 32'(e_we));
            chk("rnd_re", 32'(ram_rd_en), 32'(e_re));
            if (e_we) begin
                chk("rnd_waddr", 32'(ram_write_adress), 32'(wa ? a_addr : b_addr));
                chk("rnd_wdata", 32'(ram_data_in), 32'(wa ? a_wdata : b_wdata));
            end
            if (e_re)
                chk("rnd_raddr", 32'(ram_rd_adress), 32'(wa ? a_addr : b_addr));
            chk("rnd_arv", 32'(a_rvalid), 32'(nrv_a));
            chk("rnd_brv", 32'(b_rvalid), 32'(nrv_b));
            chk("rnd_ard", 32'(a_rdata), 32'(ea_rd));
            chk("rnd_brd", 32'(b_rdata), 32'(eb_rd));
            chk("rnd_busy", 32'(busy), 0);
            nrv_a = 0; nrv_b = 0;
            if (wa) begin
                last_b = 0; a_p = 0;
                if (a_we) ref_mem[a_addr] = a_wdata;
                else begin nrv_a = 1; nd_a = ref_mem[a_addr]; end
            end
            if (wb) begin
                last_b = 1; b_p = 0;
                if (b_we) ref_mem[b_addr] = b_wdata;
                else begin nrv_b = 1; nd_b = ref_mem[b_addr]; end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
